// File: rtl/r2sdf_butterfly_stage.sv
// Radix-2 single-path delay-feedback DIF butterfly stage; emits sums, then the fed-back differences.
// Optional R2SDF_FLUSH_EN adds a `flush` input that drains pending differences without new input.
module r2sdf_butterfly_stage #(
  parameter int DATA_WIDTH_IN  = 10,
  parameter int DATA_WIDTH_OUT = DATA_WIDTH_IN + 1,
  parameter int DELAY          = 4,
  parameter int TWIDDLE_RANK   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             din_valid,
  input  logic signed [DATA_WIDTH_IN-1:0]  din_real,
  input  logic signed [DATA_WIDTH_IN-1:0]  din_imag,
`ifdef R2SDF_FLUSH_EN
  input  logic                             flush,
`endif
  output logic                             dout_valid,
  output logic signed [DATA_WIDTH_OUT-1:0] dout_real,
  output logic signed [DATA_WIDTH_OUT-1:0] dout_imag,
  output logic [1:0]                       dout_twiddle,
  output logic                             dout_first
);

  localparam int         CNT_W   = $clog2(2 * DELAY);
  localparam int         TW_STEP = TWIDDLE_RANK / (2 * DELAY);
  localparam logic [1:0] TW_STEP2 = 2'(TW_STEP);
  localparam int         EXT_W   = DATA_WIDTH_OUT - DATA_WIDTH_IN;

  typedef struct packed {
    logic signed [DATA_WIDTH_OUT-1:0] re;
    logic signed [DATA_WIDTH_OUT-1:0] im;
  } cplx_t;

  logic [CNT_W-1:0]                 r_cnt;
  logic                             r_pend;
  cplx_t                            r_line [DELAY];
  logic                             r_dout_valid;
  logic signed [DATA_WIDTH_OUT-1:0] r_dout_real;
  logic signed [DATA_WIDTH_OUT-1:0] r_dout_imag;
  logic [1:0]                       r_dout_twiddle;
  logic                             r_dout_first;

  logic       w_accept;
  logic       w_compute;
  logic       w_emit;
  logic       w_first;
  logic       w_last_cnt;
  logic       w_last_fill;
  logic [1:0] w_cnt2;
  logic [1:0] w_twiddle;
  cplx_t      w_in;
  cplx_t      w_head;
  cplx_t      w_sum;
  cplx_t      w_diff;
  cplx_t      w_push;
  cplx_t      w_out;

  // A flush step only happens while differences are still pending; real input always wins.
`ifdef R2SDF_FLUSH_EN
  assign w_accept = din_valid | (flush & r_pend);
`else
  assign w_accept = din_valid;
`endif

  assign w_in.re = din_valid ? {{EXT_W{din_real[DATA_WIDTH_IN-1]}}, din_real} : '0;
  assign w_in.im = din_valid ? {{EXT_W{din_imag[DATA_WIDTH_IN-1]}}, din_imag} : '0;

  assign w_head      = r_line[DELAY-1];
  assign w_compute   = (r_cnt >= CNT_W'(DELAY));
  assign w_first     = (r_cnt == CNT_W'(DELAY));
  assign w_last_cnt  = (r_cnt == CNT_W'(2 * DELAY - 1));
  assign w_last_fill = (r_cnt == CNT_W'(DELAY - 1));
  assign w_emit      = w_accept & (w_compute | r_pend);

  assign w_sum.re  = w_head.re + w_in.re;
  assign w_sum.im  = w_head.im + w_in.im;
  assign w_diff.re = w_head.re - w_in.re;
  assign w_diff.im = w_head.im - w_in.im;

  assign w_push = w_compute ? w_diff : w_in;
  assign w_out  = w_compute ? w_sum  : w_head;

  // Index is only needed mod 4, so a 2-bit product of the low count bits suffices.
  assign w_cnt2    = 2'(r_cnt);
  assign w_twiddle = w_compute ? 2'd0 : 2'(w_cnt2 * TW_STEP2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_pend         <= 1'b0;
      for (int i = 0; i < DELAY; i++) r_line[i] <= '0;
      r_dout_valid   <= 1'b0;
      r_dout_real    <= '0;
      r_dout_imag    <= '0;
      r_dout_twiddle <= 2'd0;
      r_dout_first   <= 1'b0;
    end else begin
      r_dout_valid <= w_emit;
      if (w_emit) begin
        r_dout_real    <= w_out.re;
        r_dout_imag    <= w_out.im;
        r_dout_twiddle <= w_twiddle;
        r_dout_first   <= w_compute & w_first;
      end
      if (w_accept) begin
        for (int i = DELAY - 1; i > 0; i--) r_line[i] <= r_line[i-1];
        r_line[0] <= w_push;
        r_cnt     <= w_last_cnt ? '0 : r_cnt + 1'b1;
        if (w_compute && w_last_cnt)
          r_pend <= 1'b1;
        else if (!w_compute && w_last_fill)
          r_pend <= 1'b0;
      end
    end
  end

  assign dout_valid   = r_dout_valid;
  assign dout_real    = r_dout_real;
  assign dout_imag    = r_dout_imag;
  assign dout_twiddle = r_dout_twiddle;
  assign dout_first   = r_dout_first;

endmodule

// File: tb/tb_r2sdf_butterfly_stage.sv
// Directed bench for r2sdf_butterfly_stage: three instances (DELAY 4, 2, 1) with hand-computed vectors.
module tb_r2sdf_butterfly_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  logic              v4 = 0, v2 = 0, v1 = 0, f4 = 0;
  logic signed [9:0] r4 = 0, i4 = 0, r2 = 0, i2 = 0, r1 = 0, i1 = 0;

  logic              ov4, ov2, ov1, of4, of2, of1;
  logic signed [10:0] or4, oi4, or2, oi2, or1, oi1;
  logic [1:0]        ot4, ot2, ot1;

  r2sdf_butterfly_stage #(.DELAY(4)) u_d4 (
    .clk(clk), .rst(rst), .din_valid(v4), .din_real(r4), .din_imag(i4),
`ifdef R2SDF_FLUSH_EN
    .flush(f4),
`endif
    .dout_valid(ov4), .dout_real(or4), .dout_imag(oi4), .dout_twiddle(ot4), .dout_first(of4));

  r2sdf_butterfly_stage #(.DELAY(2)) u_d2 (
    .clk(clk), .rst(rst), .din_valid(v2), .din_real(r2), .din_imag(i2),
`ifdef R2SDF_FLUSH_EN
    .flush(1'b0),
`endif
    .dout_valid(ov2), .dout_real(or2), .dout_imag(oi2), .dout_twiddle(ot2), .dout_first(of2));

  r2sdf_butterfly_stage #(.DELAY(1)) u_d1 (
    .clk(clk), .rst(rst), .din_valid(v1), .din_real(r1), .din_imag(i1),
`ifdef R2SDF_FLUSH_EN
    .flush(1'b0),
`endif
    .dout_valid(ov1), .dout_real(or1), .dout_imag(oi1), .dout_twiddle(ot1), .dout_first(of1));

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv4(input bit v, input int re, input int im);
    v4 = v; r4 = re[9:0]; i4 = im[9:0];
    tick();
  endtask

  task automatic exp4(input string tag, input bit v, input int re, input int im, input int tw, input bit f);
    chk({tag, ".valid"}, int'(ov4), int'(v));
    if (v) begin
      chk({tag, ".real"}, int'(or4), re);
      chk({tag, ".imag"}, int'(oi4), im);
      chk({tag, ".tw"},   int'(ot4), tw);
      chk({tag, ".first"}, int'(of4), int'(f));
    end
  endtask

  task automatic chk_reset4(input string tag);
    chk({tag, ".valid"}, int'(ov4), 0);
    chk({tag, ".real"},  int'(or4), 0);
    chk({tag, ".imag"},  int'(oi4), 0);
    chk({tag, ".tw"},    int'(ot4), 0);
    chk({tag, ".first"}, int'(of4), 0);
  endtask

  // Frame 1..8 (imag 0): sums appear on samples 5..8 as 6,8,10,12.
  task automatic frame18(input string tag, input bit gaps);
    for (int k = 1; k <= 8; k++) begin
      drv4(1, k, 0);
      if (k <= 4) exp4(tag, 0, 0, 0, 0, 0);
      else        exp4(tag, 1, 2 * k - 4, 0, 0, k == 5);
      if (gaps) begin
        drv4(0, 0, 0);
        chk({tag, ".gapvalid"}, int'(ov4), 0);
        if (k > 4) chk({tag, ".hold"}, int'(or4), 2 * k - 4);
      end
    end
  endtask

  initial begin
    tick(); tick();
    chk_reset4("rst0");
    chk("rst0.d2valid", int'(ov2), 0);
    chk("rst0.d1valid", int'(ov1), 0);
    rst = 1'b0;

    // DELAY=2 imag path
    v2 = 1; r2 = 0;
    i2 = 10'sd3;  tick(); chk("d2.s0.valid", int'(ov2), 0);
    i2 = -10'sd2; tick(); chk("d2.s1.valid", int'(ov2), 0);
    i2 = 10'sd5;  tick();
    chk("d2.s2.valid", int'(ov2), 1); chk("d2.s2.imag", int'(oi2), 8);
    chk("d2.s2.real", int'(or2), 0);  chk("d2.s2.first", int'(of2), 1);
    chk("d2.s2.tw", int'(ot2), 0);
    i2 = 10'sd7;  tick();
    chk("d2.s3.imag", int'(oi2), 5);  chk("d2.s3.first", int'(of2), 0);
    i2 = 0; tick();
    chk("d2.f0.valid", int'(ov2), 1); chk("d2.f0.imag", int'(oi2), -2);
    chk("d2.f0.tw", int'(ot2), 0);
    tick();
    chk("d2.f1.valid", int'(ov2), 1); chk("d2.f1.imag", int'(oi2), -9);
    chk("d2.f1.tw", int'(ot2), 2);
    v2 = 0; tick();
    chk("d2.idle.valid", int'(ov2), 0);

    // DELAY=1 full-scale width check
    v1 = 1; r1 = -10'sd512; i1 = -10'sd512;
    tick(); chk("d1.s0.valid", int'(ov1), 0);
    tick();
    chk("d1.sum.valid", int'(ov1), 1); chk("d1.sum.real", int'(or1), -1024);
    chk("d1.sum.imag", int'(oi1), -1024); chk("d1.sum.first", int'(of1), 1);
    r1 = 0; i1 = 0; tick();
    chk("d1.diff.valid", int'(ov1), 1); chk("d1.diff.real", int'(or1), 0);
    chk("d1.diff.tw", int'(ot1), 0);
    v1 = 0; tick();

    // DELAY=4 contiguous frame, then zero frame draining differences
    frame18("t1", 0);
    for (int k = 0; k < 8; k++) begin
      drv4(1, 0, 0);
      if (k < 4) exp4("t2.diff", 1, -4, 0, k, 0);
      else       exp4("t2.sum", 1, 0, 0, 0, k == 4);
    end
    drv4(0, 0, 0);
    exp4("t2.idle", 0, 0, 0, 0, 0);

    // Gapped input
    rst = 1; tick(); rst = 0;
    frame18("t5", 1);

`ifdef R2SDF_FLUSH_EN
    for (int k = 0; k < 4; k++) begin
      v4 = 0; f4 = 1; tick();
      exp4("t7.flush", 1, -4, 0, k, 0);
    end
    tick();
    exp4("t7.ignored", 0, 0, 0, 0, 0);
    f4 = 0;
`endif

    // Reset mid-block, then a clean frame
    rst = 1; tick(); rst = 0;
    for (int k = 1; k <= 6; k++) drv4(1, 10 * k, 3);
    v4 = 0; rst = 1; tick(); rst = 0;
    chk_reset4("t6.rst");
    frame18("t6", 0);
    drv4(1, 0, 0);
    exp4("t6.diff0", 1, -4, 0, 0, 0);
    drv4(0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
